sdp_y_core_cfg_triosy_ctrl: RTL and testbench

Completion sequencer for the SDP Y-core config triosy objects (cfg_mul_op, cfg_mul_bypass, cfg_mul_src, …). When the HLS core finishes a layer, this block fires the triosy valid (lz) of each participating object and tracks which objects have accepted. Completion is held while downstream stalls, and a single done_ack is returned to the core only after every object has completed and the stall has cleared. It also keeps a layer counter, a wait-cycle counter and a sticky protocol-error flag. It sits between the Y-core main FSM and the bank of per-object triosy wait datapaths.

---
 rtl/sdp_y_core_cfg_triosy_ctrl.sv | 112 +++++++++++
 tb/tb_sdp_y_core_cfg_triosy_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_y_core_cfg_triosy_ctrl.sv
// Completion sequencer for the SDP Y-core config triosy objects: fires each
// participating object's lz, collects accepts, then returns one done_ack.
module sdp_y_core_cfg_triosy_ctrl #(
    parameter int unsigned NUM_OBJ = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rstn,
    input  logic               clr,
    input  logic [NUM_OBJ-1:0] obj_en,
    input  logic               done_req,
    output logic               done_ack,
    output logic [NUM_OBJ-1:0] obj_lz,
    input  logic [NUM_OBJ-1:0] obj_vz,
    input  logic               core_stall,
    output logic               busy,
    output logic [CNT_W-1:0]   layer_cnt,
    output logic [CNT_W-1:0]   wait_cnt,
    output logic               proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] WAIT_MAX = '1;

    state_t             state, state_nxt;
    logic [NUM_OBJ-1:0] pend, pend_nxt;
    logic [NUM_OBJ-1:0] mask, mask_nxt;
    logic [CNT_W-1:0]   layer_nxt, wait_nxt;
    logic               err_nxt;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state     <= IDLE;
            pend      <= '0;
            mask      <= '0;
            layer_cnt <= '0;
            wait_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pend      <= pend_nxt;
            mask      <= mask_nxt;
            layer_cnt <= layer_nxt;
            wait_cnt  <= wait_nxt;
            proto_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        mask_nxt  = mask;
        layer_nxt = layer_cnt;
        wait_nxt  = wait_cnt;
        err_nxt   = proto_err;
        done_ack  = 1'b0;
        obj_lz    = '0;
        busy      = (state != IDLE);

        // Any accept on a bit that is not currently pending is a protocol error.
        if (busy && ((obj_vz & ~pend) != '0)) begin
            err_nxt = 1'b1;
        end
        if (busy && (wait_cnt != WAIT_MAX)) begin
            wait_nxt = wait_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (done_req) begin
                    mask_nxt  = obj_en;
                    pend_nxt  = obj_en;
                    wait_nxt  = '0;
                    state_nxt = (obj_en != '0) ? ISSUE : HOLD;
                end
            end
            ISSUE: begin
                obj_lz   = pend & mask;
                pend_nxt = pend & ~obj_vz;
                if (pend_nxt == '0) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!core_stall) begin
                    done_ack  = 1'b1;
                    layer_nxt = layer_cnt + CNT_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Clear overrides everything, including this cycle's outputs.
        if (clr) begin
            state_nxt = IDLE;
            pend_nxt  = '0;
            mask_nxt  = '0;
            layer_nxt = '0;
            wait_nxt  = '0;
            err_nxt   = 1'b0;
            done_ack  = 1'b0;
            obj_lz    = '0;
        end
    end

endmodule

// File: tb/tb_sdp_y_core_cfg_triosy_ctrl.sv
// Scoreboard bench for sdp_y_core_cfg_triosy_ctrl: layers are described as
// per-object accept times plus stall length; a monitor checks acks and lz.
module tb_sdp_y_core_cfg_triosy_ctrl;

    localparam int NUM_OBJ = 4;
    localparam int CNT_W   = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic               clr;
    logic [NUM_OBJ-1:0] obj_en;
    logic               done_req;
    logic               done_ack;
    logic [NUM_OBJ-1:0] obj_lz;
    logic [NUM_OBJ-1:0] obj_vz;
    logic               core_stall;
    logic               busy;
    logic [CNT_W-1:0]   layer_cnt;
    logic [CNT_W-1:0]   wait_cnt;
    logic               proto_err;

    always #5 clk = ~clk;

    sdp_y_core_cfg_triosy_ctrl #(.NUM_OBJ(NUM_OBJ), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rstn(rstn),
        .clr            (clr),
        .obj_en         (obj_en),
        .done_req       (done_req),
        .done_ack       (done_ack),
        .obj_lz         (obj_lz),
        .obj_vz         (obj_vz),
        .core_stall     (core_stall),
        .busy           (busy),
        .layer_cnt      (layer_cnt),
        .wait_cnt       (wait_cnt),
        .proto_err      (proto_err)
    );

    typedef int acc_t[NUM_OBJ];
    typedef struct {
        int acc;
        int lat;
        int layer;
        int waitv;
        bit err;
    } ack_t;
    typedef struct {
        int         cyc;
        logic [3:0] lz;
        bit         bsy;
    } cyc_t;

    ack_t sbq[$];
    cyc_t lzq[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   layers = 0;
    bit   err_m = 1'b0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [3:0] pend_at(logic [3:0] e, acc_t a, int c);
        logic [3:0] p = '0;
        for (int i = 0; i < NUM_OBJ; i++) if (e[i] && a[i] >= c) p[i] = 1'b1;
        return p;
    endfunction

    function automatic logic [3:0] acc_at(logic [3:0] e, acc_t a, int c);
        logic [3:0] p = '0;
        for (int i = 0; i < NUM_OBJ; i++) if (e[i] && a[i] == c) p[i] = 1'b1;
        return p;
    endfunction

    // Monitor: per-cycle lz/busy expectations and ack-time expectations.
    bit   post_pend = 1'b0;
    int   post_wait, post_layer;
    cyc_t ce;
    ack_t ae;
    always @(negedge clk) begin
        if (post_pend) begin
            chk("wait_after_ack", 32'(wait_cnt), post_wait);
            chk("layer_after_ack", 32'(layer_cnt), post_layer);
            post_pend = 1'b0;
        end
        if (lzq.size() > 0 && lzq[0].cyc == cyc) begin
            ce = lzq.pop_front();
            chk("obj_lz", 32'(obj_lz), 32'(ce.lz));
            chk("busy", 32'(busy), 32'(ce.bsy));
        end
        if (done_ack === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", 32'(done_ack), 0);
            end else begin
                ae = sbq.pop_front();
                chk("ack_latency", cyc - ae.acc + 1, ae.lat);
                chk("layer_at_ack", 32'(layer_cnt), ae.layer);
                chk("wait_at_ack", 32'(wait_cnt), ae.waitv);
                chk("proto_err_at_ack", 32'(proto_err), 32'(ae.err));
                post_pend  = 1'b1;
                post_wait  = (ae.lat > CMAX) ? CMAX : ae.lat;
                post_layer = (ae.layer + 1) % (CMAX + 1);
            end
        end
    end

    // One layer from an IDLE cycle: accept times a[i] (1 = first ISSUE cycle),
    // s stall cycles in HOLD, optional random strays plus a forced cycle-1 stray.
    task automatic run_layer(logic [3:0] e, acc_t a, int s, bit rnd_stray, logic [3:0] st1);
        int         l = 0;
        int         lat;
        int         b;
        bit         any = 1'b0;
        logic [3:0] strayv[0:31];
        logic [3:0] fr;
        for (int i = 0; i < NUM_OBJ; i++) if (e[i] && a[i] > l) l = a[i];
        lat = (e == 4'b0) ? 1 + s : l + 1 + s;
        for (int c = 0; c < 32; c++) strayv[c] = '0;
        for (int c = 1; c <= l; c++) begin
            fr = ~pend_at(e, a, c);
            if (rnd_stray && $urandom_range(0, 7) == 0 && fr != 4'b0) begin
                do b = $urandom_range(0, NUM_OBJ - 1); while (!fr[b]);
                strayv[c][b] = 1'b1;
                any = 1'b1;
            end
        end
        if (l >= 1 && st1 != 4'b0) begin
            strayv[1] = strayv[1] | st1;
            any = 1'b1;
        end
        err_m = err_m | any;
        sbq.push_back(ack_t'{cyc + 1, lat, layers % (CMAX + 1),
                             (lat - 1 > CMAX) ? CMAX : lat - 1, err_m});
        layers++;

        clr = 1'b0; done_req = 1'b1; obj_en = e;
        obj_vz = 4'($urandom); core_stall = 1'($urandom);
        lzq.push_back(cyc_t'{cyc, 4'b0, 1'b0});
        @(posedge clk); #1;
        for (int c = 1; c <= lat; c++) begin
            obj_vz     = (c <= l) ? (acc_at(e, a, c) | strayv[c]) : 4'b0;
            core_stall = (c <= l) ? 1'($urandom) : (c < lat);
            done_req   = 1'($urandom);
            obj_en     = 4'($urandom);
            lzq.push_back(cyc_t'{cyc, (c <= l) ? pend_at(e, a, c) : 4'b0, 1'b1});
            @(posedge clk); #1;
        end
        done_req = 1'b0; obj_vz = '0; core_stall = 1'b0;
    endtask

    task automatic gap();
        clr = 1'b0; done_req = 1'b0; obj_vz = 4'($urandom); core_stall = 1'($urandom);
        lzq.push_back(cyc_t'{cyc, 4'b0, 1'b0});
        @(posedge clk); #1;
        obj_vz = '0;
    endtask

    task automatic clr_idle();
        clr = 1'b1; done_req = 1'b1; obj_en = 4'($urandom); obj_vz = 4'($urandom);
        lzq.push_back(cyc_t'{cyc, 4'b0, 1'b0});
        @(posedge clk); #1;
        clr = 1'b0; done_req = 1'b0; obj_vz = '0;
        layers = 0; err_m = 1'b0;
        chk("clr_layer", 32'(layer_cnt), 0);
        chk("clr_wait", 32'(wait_cnt), 0);
        chk("clr_proto_err", 32'(proto_err), 0);
        chk("clr_busy", 32'(busy), 0);
    endtask

    task automatic clr_mid_issue();
        clr = 1'b0; done_req = 1'b1; obj_en = 4'b0011; obj_vz = '0;
        lzq.push_back(cyc_t'{cyc, 4'b0, 1'b0});
        @(posedge clk); #1;
        done_req = 1'b0;
        lzq.push_back(cyc_t'{cyc, 4'b0011, 1'b1});
        @(posedge clk); #1;
        clr = 1'b1;
        lzq.push_back(cyc_t'{cyc, 4'b0, 1'b1});
        @(posedge clk); #1;
        clr = 1'b0; layers = 0; err_m = 1'b0;
        chk("clr_issue_busy", 32'(busy), 0);
        chk("clr_issue_lz", 32'(obj_lz), 0);
        chk("clr_issue_layer", 32'(layer_cnt), 0);
    endtask

    task automatic reset_mid_hold();
        clr = 1'b0; done_req = 1'b1; obj_en = 4'hF; obj_vz = '0;
        lzq.push_back(cyc_t'{cyc, 4'b0, 1'b0});
        @(posedge clk); #1;
        done_req = 1'b0; obj_vz = 4'hF;
        lzq.push_back(cyc_t'{cyc, 4'hF, 1'b1});
        @(posedge clk); #1;
        obj_vz = '0; core_stall = 1'b1;
        chk("hold_busy", 32'(busy), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ack", 32'(done_ack), 0);
        chk("rst_lz", 32'(obj_lz), 0);
        chk("rst_layer", 32'(layer_cnt), 0);
        chk("rst_wait", 32'(wait_cnt), 0);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1; core_stall = 1'b0; layers = 0; err_m = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_busy", 32'(busy), 0);
        gap();
        chk("post_rst_busy2", 32'(busy), 0);
    endtask

    task automatic rand_layer(bit allow_clr);
        logic [3:0] e;
        acc_t       a;
        int         s;
        e = 4'($urandom);
        for (int i = 0; i < NUM_OBJ; i++) a[i] = $urandom_range(1, 4);
        s = ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 2);
        run_layer(e, a, s, 1'b1, 4'b0);
        if ($urandom_range(0, 3) == 0) gap();
        if (allow_clr && $urandom_range(0, 24) == 0) clr_idle();
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; done_req = 1'b0; obj_en = '0; obj_vz = '0; core_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ack", 32'(done_ack), 0);
        chk("reset_lz", 32'(obj_lz), 0);
        chk("reset_layer", 32'(layer_cnt), 0);
        chk("reset_wait", 32'(wait_cnt), 0);
        chk("reset_proto_err", 32'(proto_err), 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("release_busy", 32'(busy), 0);

        run_layer(4'hF, '{1, 1, 1, 1}, 0, 1'b0, 4'b0);
        run_layer(4'b0101, '{1, 1, 4, 1}, 0, 1'b0, 4'b0);
        run_layer(4'hF, '{1, 1, 1, 1}, 5, 1'b0, 4'b0);
        run_layer(4'b0, '{1, 1, 1, 1}, 0, 1'b0, 4'b0);
        run_layer(4'b0001, '{2, 1, 1, 1}, 0, 1'b0, 4'b0010);
        gap();
        chk("proto_err_sticky", 32'(proto_err), 1);
        clr_idle();
        clr_mid_issue();
        run_layer(4'hF, '{1, 2, 3, 4}, 20, 1'b0, 4'b0);

        for (int n = 0; n < 20; n++) rand_layer(1'b0);
        for (int n = 0; n < 60; n++) rand_layer(1'b1);
        reset_mid_hold();
        for (int n = 0; n < 10; n++) rand_layer(1'b1);

        gap();
        gap();
        chk("acks_outstanding", sbq.size(), 0);
        chk("cycles_outstanding", lzq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
